// File: rtl/scr1_timer_mc_pkg.sv
// Shared definitions for the multi-channel machine timer: DMEM bus encodings,
// register offsets, channel window layout, CONTROL bit positions and channel modes.
package scr1_timer_mc_pkg;

    localparam int unsigned SCR1_DMEM_AWIDTH = 32;
    localparam int unsigned SCR1_DMEM_DWIDTH = 32;

    localparam logic       SCR1_MEM_CMD_RD        = 1'b0;
    localparam logic       SCR1_MEM_CMD_WR        = 1'b1;
    localparam logic [1:0] SCR1_MEM_WIDTH_WORD    = 2'b10;
    localparam logic [1:0] SCR1_MEM_RESP_NOTRDY   = 2'b00;
    localparam logic [1:0] SCR1_MEM_RESP_RDY_OK   = 2'b01;
    localparam logic [1:0] SCR1_MEM_RESP_RDY_ER   = 2'b10;

    // Global register byte offsets
    localparam logic [7:0] SCR1_TIMER_CONTROL = 8'h00;
    localparam logic [7:0] SCR1_TIMER_DIVIDER = 8'h04;
    localparam logic [7:0] SCR1_TIMER_MTIMELO = 8'h08;
    localparam logic [7:0] SCR1_TIMER_MTIMEHI = 8'h0C;
    localparam logic [7:0] SCR1_TIMER_PENDING = 8'h10;
    localparam logic [7:0] SCR1_TIMER_IE      = 8'h14;
    localparam logic [7:0] SCR1_TIMER_GLB_END = 8'h18;

    // Channel windows
    localparam logic [7:0] SCR1_TIMER_CH_BASE   = 8'h20;
    localparam logic [7:0] SCR1_TIMER_CH_STRIDE = 8'h10;
    localparam logic [3:0] SCR1_TIMER_CH_CMPLO  = 4'h0;
    localparam logic [3:0] SCR1_TIMER_CH_CMPHI  = 4'h4;
    localparam logic [3:0] SCR1_TIMER_CH_MODE   = 4'h8;
    localparam logic [3:0] SCR1_TIMER_CH_PERIOD = 4'hC;

    // CONTROL bit positions
    localparam int unsigned SCR1_TIMER_CTRL_EN_BIT     = 0;
    localparam int unsigned SCR1_TIMER_CTRL_CLKSRC_BIT = 1;

    typedef enum logic [1:0] {
        LEVEL    = 2'd0,
        ONESHOT  = 2'd1,
        PERIODIC = 2'd2,
        OFF      = 2'd3
    } type_scr1_timer_mode_e;

endpackage

// File: rtl/scr1_timer_mc_chan.sv
// One compare channel: 64-bit compare value, mode, reload period and pending bit.
// Ports: clk_i/rst_i (sync, active-high), mtime_i (current mtime register),
// *_we_i decoded write strobes with wdata_i, pend_w1c_i clear request,
// cmp_o/mode_o/period_o/pending_o register views for readback and IRQ.
module scr1_timer_mc_chan
    import scr1_timer_mc_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [63:0]           mtime_i,
    input  logic                  cmplo_we_i,
    input  logic                  cmphi_we_i,
    input  logic                  mode_we_i,
    input  logic                  period_we_i,
    input  logic                  pend_w1c_i,
    input  logic [31:0]           wdata_i,
    output logic [63:0]           cmp_o,
    output type_scr1_timer_mode_e mode_o,
    output logic [31:0]           period_o,
    output logic                  pending_o
);

    logic [63:0]           cmp_q, cmp_d, cmp_eff;
    type_scr1_timer_mode_e mode_q, mode_d;
    logic [31:0]           period_q, period_d;
    logic                  pend_q, pend_d;
    logic                  match;

    // A same-cycle compare write is already visible to the match
    always_comb begin
        cmp_eff = cmp_q;
        if (cmplo_we_i) cmp_eff[31:0]  = wdata_i;
        if (cmphi_we_i) cmp_eff[63:32] = wdata_i;
    end

    assign match = (mtime_i >= cmp_eff);

    always_comb begin
        cmp_d    = cmp_eff;
        mode_d   = mode_q;
        period_d = period_q;
        pend_d   = pend_q & ~pend_w1c_i;  // a set below overrides the clear
        case (mode_q)
            LEVEL: pend_d = match;
            ONESHOT: begin
                if (match) begin
                    pend_d = 1'b1;
                    mode_d = OFF;
                end
            end
            PERIODIC: begin
                if (match) begin
                    pend_d = 1'b1;
                    // Software compare write wins over the auto-reload
                    if (!(cmplo_we_i || cmphi_we_i)) cmp_d = cmp_q + {32'd0, period_q};
                end
            end
            OFF: ;
            default: ;
        endcase
        if (mode_we_i)   mode_d   = type_scr1_timer_mode_e'(wdata_i[1:0]);
        if (period_we_i) period_d = wdata_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cmp_q    <= '1;
            mode_q   <= LEVEL;
            period_q <= '0;
            pend_q   <= 1'b0;
        end else begin
            cmp_q    <= cmp_d;
            mode_q   <= mode_d;
            period_q <= period_d;
            pend_q   <= pend_d;
        end
    end

    assign cmp_o     = cmp_q;
    assign mode_o    = mode_q;
    assign period_o  = period_q;
    assign pending_o = pend_q;

endmodule

// File: rtl/scr1_timer_mc.sv
// Multi-channel memory-mapped machine timer on the DMEM port.
// Ports: clk_i/rst_i (sync, active-high), rtc_in_i (async RTC level),
// dmem_* request/response (registered response, always acked),
// timer_val_o (mtime), timer_irq_o (pending & IE per channel), timer_irq_any_o.
module scr1_timer_mc
    import scr1_timer_mc_pkg::*;
#(
    parameter int unsigned NCH       = 4,
    parameter int unsigned DIV_WIDTH = 10
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        rtc_in_i,
    input  logic                        dmem_req_i,
    input  logic                        dmem_cmd_i,
    input  logic [1:0]                  dmem_width_i,
    input  logic [SCR1_DMEM_AWIDTH-1:0] dmem_addr_i,
    input  logic [SCR1_DMEM_DWIDTH-1:0] dmem_wdata_i,
    output logic                        dmem_req_ack_o,
    output logic [SCR1_DMEM_DWIDTH-1:0] dmem_rdata_o,
    output logic [1:0]                  dmem_resp_o,
    output logic [63:0]                 timer_val_o,
    output logic [NCH-1:0]              timer_irq_o,
    output logic                        timer_irq_any_o
);

    logic                 en_q, en_d, rtc_sel_q, rtc_sel_d;
    logic [DIV_WIDTH-1:0] div_q, div_d, cnt_q, cnt_d;
    logic [63:0]          mtime_q, mtime_d;
    logic [NCH-1:0]       ie_q, ie_d;
    logic [2:0]           rtc_sync_q;
    logic [31:0]          rdata_q, rdata_d, rd_val;
    logic [1:0]           resp_q, resp_d;

    // Address decode: only the low byte matters
    logic [7:0] addr, ch_rel;
    logic [3:0] ch_idx, ch_off;
    logic       glb_hit, ch_hit, acc_valid, wr_en, rtc_pulse, cnt_en, tick;
    logic       unused_addr;

    assign addr        = dmem_addr_i[7:0];
    assign unused_addr = ^dmem_addr_i[SCR1_DMEM_AWIDTH-1:8];
    assign ch_rel      = addr - SCR1_TIMER_CH_BASE;
    assign ch_idx      = ch_rel[7:4];
    assign ch_off      = ch_rel[3:0];
    assign glb_hit     = (addr < SCR1_TIMER_GLB_END);
    assign ch_hit      = (addr >= SCR1_TIMER_CH_BASE) && (32'(ch_idx) < NCH);
    assign acc_valid   = (dmem_width_i == SCR1_MEM_WIDTH_WORD) && (addr[1:0] == 2'b00)
                         && (glb_hit || ch_hit);
    assign wr_en       = dmem_req_i && (dmem_cmd_i == SCR1_MEM_CMD_WR) && acc_valid;

    // Channels
    logic [63:0]           ch_cmp    [NCH];
    type_scr1_timer_mode_e ch_mode   [NCH];
    logic [31:0]           ch_period [NCH];
    logic [NCH-1:0]        ch_pend;

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        logic sel;
        assign sel = wr_en && ch_hit && (ch_idx == 4'(i));
        scr1_timer_mc_chan u_chan (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .mtime_i     (mtime_q),
            .cmplo_we_i  (sel && (ch_off == SCR1_TIMER_CH_CMPLO)),
            .cmphi_we_i  (sel && (ch_off == SCR1_TIMER_CH_CMPHI)),
            .mode_we_i   (sel && (ch_off == SCR1_TIMER_CH_MODE)),
            .period_we_i (sel && (ch_off == SCR1_TIMER_CH_PERIOD)),
            .pend_w1c_i  (wr_en && (addr == SCR1_TIMER_PENDING) && dmem_wdata_i[i]),
            .wdata_i     (dmem_wdata_i),
            .cmp_o       (ch_cmp[i]),
            .mode_o      (ch_mode[i]),
            .period_o    (ch_period[i]),
            .pending_o   (ch_pend[i])
        );
    end

    // Tick generation: rising edge after a two-flop synchroniser
    assign rtc_pulse = rtc_sync_q[1] & ~rtc_sync_q[2];
    assign cnt_en    = en_q & (rtc_sel_q ? rtc_pulse : 1'b1);
    assign tick      = cnt_en & (cnt_q == '0);

    always_comb begin
        en_d      = en_q;
        rtc_sel_d = rtc_sel_q;
        div_d     = div_q;
        ie_d      = ie_q;
        cnt_d     = cnt_q;
        mtime_d   = tick ? (mtime_q + 64'd1) : mtime_q;
        if (tick)        cnt_d = div_q;
        else if (cnt_en) cnt_d = cnt_q - DIV_WIDTH'(1);
        if (wr_en) begin
            case (addr)
                SCR1_TIMER_CONTROL: begin
                    en_d      = dmem_wdata_i[SCR1_TIMER_CTRL_EN_BIT];
                    rtc_sel_d = dmem_wdata_i[SCR1_TIMER_CTRL_CLKSRC_BIT];
                end
                SCR1_TIMER_DIVIDER: begin
                    div_d = dmem_wdata_i[DIV_WIDTH-1:0];
                    cnt_d = dmem_wdata_i[DIV_WIDTH-1:0];
                end
                SCR1_TIMER_MTIMELO: mtime_d[31:0]  = dmem_wdata_i;
                SCR1_TIMER_MTIMEHI: mtime_d[63:32] = dmem_wdata_i;
                SCR1_TIMER_IE:      ie_d           = dmem_wdata_i[NCH-1:0];
                default: ;
            endcase
        end
    end

    // Readback uses pre-write register values
    always_comb begin
        rd_val = '0;
        if (glb_hit) begin
            case (addr)
                SCR1_TIMER_CONTROL: rd_val = {30'd0, rtc_sel_q, en_q};
                SCR1_TIMER_DIVIDER: rd_val = 32'(div_q);
                SCR1_TIMER_MTIMELO: rd_val = mtime_q[31:0];
                SCR1_TIMER_MTIMEHI: rd_val = mtime_q[63:32];
                SCR1_TIMER_PENDING: rd_val = 32'(ch_pend);
                SCR1_TIMER_IE:      rd_val = 32'(ie_q);
                default: ;
            endcase
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (ch_idx == 4'(i)) begin
                    case (ch_off)
                        SCR1_TIMER_CH_CMPLO:  rd_val = ch_cmp[i][31:0];
                        SCR1_TIMER_CH_CMPHI:  rd_val = ch_cmp[i][63:32];
                        SCR1_TIMER_CH_MODE:   rd_val = {30'd0, ch_mode[i]};
                        SCR1_TIMER_CH_PERIOD: rd_val = ch_period[i];
                        default: ;
                    endcase
                end
            end
        end
    end

    always_comb begin
        resp_d  = SCR1_MEM_RESP_NOTRDY;
        rdata_d = '0;
        if (dmem_req_i) begin
            if (acc_valid) begin
                resp_d = SCR1_MEM_RESP_RDY_OK;
                if (dmem_cmd_i == SCR1_MEM_CMD_RD) rdata_d = rd_val;
            end else begin
                resp_d = SCR1_MEM_RESP_RDY_ER;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            en_q       <= 1'b1;
            rtc_sel_q  <= 1'b0;
            div_q      <= '0;
            cnt_q      <= '0;
            mtime_q    <= '0;
            ie_q       <= NCH'(1);
            rtc_sync_q <= '0;
            rdata_q    <= '0;
            resp_q     <= SCR1_MEM_RESP_NOTRDY;
        end else begin
            en_q       <= en_d;
            rtc_sel_q  <= rtc_sel_d;
            div_q      <= div_d;
            cnt_q      <= cnt_d;
            mtime_q    <= mtime_d;
            ie_q       <= ie_d;
            rtc_sync_q <= {rtc_sync_q[1:0], rtc_in_i};
            rdata_q    <= rdata_d;
            resp_q     <= resp_d;
        end
    end

    assign dmem_req_ack_o  = 1'b1;
    assign dmem_rdata_o    = rdata_q;
    assign dmem_resp_o     = resp_q;
    assign timer_val_o     = mtime_q;
    assign timer_irq_o     = ch_pend & ie_q;
    assign timer_irq_any_o = |timer_irq_o;

endmodule
